// File: rtl/hex_display_scan_if.sv
// Bundle between the value producer and the multiplexed seven-segment scanner.
// The producer side drives value/control, the scanner side drives the display pins.
interface hex_display_scan_if #(
  parameter int NUM_DIGITS = 4
);
  logic                      enable;
  logic                      load;
  logic [4*NUM_DIGITS-1:0]   value;
  logic [NUM_DIGITS-1:0]     dp_in;
  logic                      mode_bcd;
  logic                      blank_lz;
  logic [6:0]                seven_seg;
  logic                      dp_n;
  logic [NUM_DIGITS-1:0]     digit_sel;
  logic                      frame_done;

  modport master (
    output enable, load, value, dp_in, mode_bcd, blank_lz,
    input  seven_seg, dp_n, digit_sel, frame_done
  );

  modport slave (
    input  enable, load, value, dp_in, mode_bcd, blank_lz,
    output seven_seg, dp_n, digit_sel, frame_done
  );
endinterface

// File: rtl/hex_display_scan.sv
// Time-multiplexed N-digit seven-segment driver (common anode, active-low pins).
// Double-buffered display data swaps only at frame wrap so a frame never tears.
module hex_display_scan #(
  parameter int NUM_DIGITS = 4,
  parameter int CLK_DIV    = 50000
) (
  input logic              clk,
  input logic              rst_n,
  hex_display_scan_if.slave bus
);
  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int VW = 4 * NUM_DIGITS;

  logic [PW-1:0]         presc_reg;
  logic [IW-1:0]         idx_reg;
  logic [VW-1:0]         act_val_reg, pend_val_reg;
  logic [NUM_DIGITS-1:0] act_dp_reg, pend_dp_reg;
  logic                  act_bcd_reg, act_lz_reg, pend_bcd_reg, pend_lz_reg;
  logic                  pend_flag_reg;

  logic [6:0]            seg_reg, seg_next;
  logic                  dp_reg, dp_next;
  logic [NUM_DIGITS-1:0] sel_reg, sel_next;
  logic                  fd_reg, fd_next;

  logic tick, last, wrap;
  assign tick = bus.enable && (presc_reg == PW'(CLK_DIV - 1));
  assign last = (idx_reg == IW'(NUM_DIGITS - 1));
  assign wrap = tick && last;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'b0000001;
      4'h1: hex7 = 7'b1001111;
      4'h2: hex7 = 7'b0010010;
      4'h3: hex7 = 7'b0000110;
      4'h4: hex7 = 7'b1001100;
      4'h5: hex7 = 7'b0100100;
      4'h6: hex7 = 7'b0100000;
      4'h7: hex7 = 7'b0001111;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0000100;
      4'hA: hex7 = 7'b0000010;
      4'hB: hex7 = 7'b1100000;
      4'hC: hex7 = 7'b0110001;
      4'hD: hex7 = 7'b1000010;
      4'hE: hex7 = 7'b0110000;
      default: hex7 = 7'b0111000;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_reg <= '0;
      idx_reg   <= '0;
    end else if (tick) begin
      presc_reg <= '0;
      idx_reg   <= last ? '0 : idx_reg + IW'(1);
    end else if (bus.enable) begin
      presc_reg <= presc_reg + PW'(1);
    end
  end

  // A load landing on the wrap edge bypasses the pending buffer entirely.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      act_val_reg   <= '0;
      act_dp_reg    <= '0;
      act_bcd_reg   <= 1'b0;
      act_lz_reg    <= 1'b0;
      pend_val_reg  <= '0;
      pend_dp_reg   <= '0;
      pend_bcd_reg  <= 1'b0;
      pend_lz_reg   <= 1'b0;
      pend_flag_reg <= 1'b0;
    end else if (bus.load) begin
      if (wrap) begin
        act_val_reg   <= bus.value;
        act_dp_reg    <= bus.dp_in;
        act_bcd_reg   <= bus.mode_bcd;
        act_lz_reg    <= bus.blank_lz;
        pend_flag_reg <= 1'b0;
      end else begin
        pend_val_reg  <= bus.value;
        pend_dp_reg   <= bus.dp_in;
        pend_bcd_reg  <= bus.mode_bcd;
        pend_lz_reg   <= bus.blank_lz;
        pend_flag_reg <= 1'b1;
      end
    end else if (pend_flag_reg && (wrap || !bus.enable)) begin
      act_val_reg   <= pend_val_reg;
      act_dp_reg    <= pend_dp_reg;
      act_bcd_reg   <= pend_bcd_reg;
      act_lz_reg    <= pend_lz_reg;
      pend_flag_reg <= 1'b0;
    end
  end

  logic [3:0]            nib [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] blanked;

  // A digit is a leading zero when it and every more significant nibble are zero.
  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign nib[gi] = act_val_reg[4*gi +: 4];
      if (gi == 0) begin : g_lsd
        assign blanked[gi] = 1'b0;
      end else begin : g_upper
        assign blanked[gi] = act_lz_reg && (act_val_reg[VW-1:4*gi] == '0);
      end
    end
  endgenerate

  logic [3:0] cur_nib;
  assign cur_nib = nib[idx_reg];

  always_comb begin
    seg_next = 7'b1111111;
    dp_next  = 1'b1;
    sel_next = '1;
    fd_next  = 1'b0;
    if (bus.enable) begin
      fd_next = wrap;
      // The slot-advance cycle stays dark to stop the old segments ghosting.
      if (!tick) begin
        sel_next[idx_reg] = 1'b0;
        dp_next           = ~act_dp_reg[idx_reg];
        if (!blanked[idx_reg]) begin
          seg_next = (act_bcd_reg && (cur_nib > 4'd9)) ? 7'b1111110 : hex7(cur_nib);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg_reg <= 7'b1111111;
      dp_reg  <= 1'b1;
      sel_reg <= '1;
      fd_reg  <= 1'b0;
    end else begin
      seg_reg <= seg_next;
      dp_reg  <= dp_next;
      sel_reg <= sel_next;
      fd_reg  <= fd_next;
    end
  end

  assign bus.seven_seg  = seg_reg;
  assign bus.dp_n       = dp_reg;
  assign bus.digit_sel  = sel_reg;
  assign bus.frame_done = fd_reg;
endmodule
